// File: rtl/bus_grant_mux.sv
// bus_grant_mux: forwards the single granted master onto one slave port; BUS_GRANT_MUX_TIMEOUT_EN adds a BUSY abort.
// Latency: s_req_o 1 cycle after grant+req, ack_o/err_o 1 cycle after s_ack_i or expiry, then a 1-cycle DONE gap.
// Backpressure: the slave stalls by withholding s_ack_i; master inputs are ignored until the FSM is back in IDLE.
module bus_grant_mux #(
  parameter int Count         = 3,
  parameter int AddrWidth     = 16,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [Count-1:0]             grant_i,
  input  logic [Count-1:0]             req_i,
  input  logic [Count-1:0]             we_i,
  input  logic [Count*AddrWidth-1:0]   addr_i,
  input  logic [Count*DataWidth-1:0]   wdata_i,
  output logic [Count-1:0]             ack_o,
  output logic [Count-1:0]             err_o,
  output logic [DataWidth-1:0]         rdata_o,
  output logic                         s_req_o,
  output logic                         s_we_o,
  output logic [AddrWidth-1:0]         s_addr_o,
  output logic [DataWidth-1:0]         s_wdata_o,
  input  logic                         s_ack_i,
  input  logic [DataWidth-1:0]         s_rdata_i
);

  localparam int IdxWidth = (Count > 1) ? $clog2(Count) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
  } cmd_t;

  state_e               state_q, state_d;
  logic [IdxWidth-1:0]  idx_q, idx_d;
  cmd_t                 cmd_q, cmd_d;
  logic                 s_req_q, s_req_d;
  logic [Count-1:0]     ack_q, ack_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;

  logic                 grant_onehot;
  logic                 start;
  logic [IdxWidth-1:0]  grant_idx;
  cmd_t                 sel_cmd;
  logic [Count-1:0]     idx_mask;

  // Only meaningful when grant_i is one-hot; otherwise start blocks its use.
  always_comb begin
    grant_idx = '0;
    sel_cmd   = '0;
    for (int k = 0; k < Count; k++) begin
      if (grant_i[k]) begin
        grant_idx     = IdxWidth'(k);
        sel_cmd.we    = we_i[k];
        sel_cmd.addr  = addr_i[k*AddrWidth +: AddrWidth];
        sel_cmd.wdata = wdata_i[k*DataWidth +: DataWidth];
      end
    end
  end

  assign grant_onehot = $onehot(grant_i);
  assign start        = grant_onehot && ((grant_i & req_i) != '0);
  assign idx_mask     = Count'(1) << idx_q;

`ifdef BUS_GRANT_MUX_TIMEOUT_EN
  localparam int CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [Count-1:0]    err_q, err_d;
  logic                expired;

  assign expired = (cnt_q == CntWidth'(TimeoutCycles - 1));
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cmd_d   = cmd_q;
    s_req_d = s_req_q;
    rdata_d = rdata_q;
    ack_d   = '0;
`ifdef BUS_GRANT_MUX_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = grant_idx;
          cmd_d   = sel_cmd;
          s_req_d = 1'b1;
          state_d = BUSY;
`ifdef BUS_GRANT_MUX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        // An ack in the expiry cycle takes precedence over the abort.
        if (s_ack_i) begin
          rdata_d = s_rdata_i;
          ack_d   = idx_mask;
          s_req_d = 1'b0;
          state_d = DONE;
        end
`ifdef BUS_GRANT_MUX_TIMEOUT_EN
        else if (expired) begin
          err_d   = idx_mask;
          s_req_d = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CntWidth'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        s_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cmd_q   <= '0;
      s_req_q <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
      s_req_q <= s_req_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef BUS_GRANT_MUX_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = '0;
`endif

  assign ack_o     = ack_q;
  assign rdata_o   = rdata_q;
  assign s_req_o   = s_req_q;
  assign s_we_o    = cmd_q.we;
  assign s_addr_o  = cmd_q.addr;
  assign s_wdata_o = cmd_q.wdata;

  a_single_completion : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(ack_o | err_o));

endmodule

// File: tb/tb_bus_grant_mux.sv
// Self-checking bench for bus_grant_mux: vector table plus timeout and reset sequences, scoreboarded acks.
module tb_bus_grant_mux;

  localparam int Count = 3;
  localparam int AW    = 16;
  localparam int DW    = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [Count-1:0]    grant_i, req_i, we_i;
  logic [Count*AW-1:0] addr_i;
  logic [Count*DW-1:0] wdata_i;
  logic [Count-1:0]    ack_o, err_o;
  logic [DW-1:0]       rdata_o;
  logic                s_req_o, s_we_o;
  logic [AW-1:0]       s_addr_o;
  logic [DW-1:0]       s_wdata_o;
  logic                s_ack_i;
  logic [DW-1:0]       s_rdata_i;

  always #5 clk = ~clk;

  bus_grant_mux #(
    .Count(Count), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .grant_i(grant_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_ack_i(s_ack_i), .s_rdata_i(s_rdata_i)
  );

  typedef struct {
    logic [2:0]  grant;
    logic [2:0]  req;
    logic        we;
    int          master;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        start;
  } vec_t;

  typedef struct {
    logic [2:0]  ack;
    logic [31:0] rdata;
  } exp_t;

  vec_t        vecs[8];
  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_rd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_all();
    for (int k = 0; k < Count; k++) begin
      addr_i[k*AW +: AW]  = 16'($urandom());
      wdata_i[k*DW +: DW] = $urandom();
    end
  endtask

  task automatic drive_req(input logic [2:0] g, input logic [2:0] r, input logic w,
                           input int m, input logic [15:0] a, input logic [31:0] d);
    grant_i = g;
    req_i   = r;
    we_i    = {3{~w}};
    we_i[m] = w;
    scramble_all();
    addr_i[m*AW +: AW]  = a;
    wdata_i[m*DW +: DW] = d;
  endtask

  task automatic start_txn(input int m, input logic w, input logic [15:0] a,
                           input logic [31:0] d, input logic [31:0] rd, input logic expect_ack);
    logic [2:0] oh;
    oh = 3'(1 << m);
    drive_req(oh, oh, w, m, a, d);
    tick();
    check("start_s_req", s_req_o, 1);
    check("start_s_we", s_we_o, w);
    check("start_s_addr", s_addr_o, a);
    check("start_s_wdata", s_wdata_o, d);
    check("start_no_ack", ack_o, 0);
    if (expect_ack) exp_q.push_back('{ack: oh, rdata: rd});
  endtask

  task automatic finish_txn(input int delay, input logic [31:0] rd, input logic w,
                            input logic [15:0] a, input logic [31:0] d);
    exp_t e;
    grant_i = 3'($urandom());
    req_i   = '0;
    we_i    = ~we_i;
    scramble_all();
    for (int i = 0; i < delay; i++) begin
      tick();
      check("hold_s_req", s_req_o, 1);
      check("hold_s_we", s_we_o, w);
      check("hold_s_addr", s_addr_o, a);
      check("hold_s_wdata", s_wdata_o, d);
      check("hold_no_ack", ack_o, 0);
    end
    s_ack_i   = 1'b1;
    s_rdata_i = rd;
    tick();
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: got ack_o 0x%0h, expected a queued entry", ack_o);
    end else begin
      e = exp_q.pop_front();
      check("ack_o", ack_o, e.ack);
      check("rdata_o", rdata_o, e.rdata);
    end
    check("ack_s_req_drop", s_req_o, 0);
    check("ack_no_err", err_o, 0);
    s_rdata_i = ~rd;
    tick();
    check("ack_one_cycle", ack_o, 0);
    check("done_s_req", s_req_o, 0);
    check("rdata_hold", rdata_o, rd);
    last_rd = rd;
    s_ack_i = 1'b0;
    grant_i = '0;
    req_i   = '0;
  endtask

  task automatic idle_vec(input vec_t v);
    drive_req(v.grant, v.req, v.we, v.master, v.addr, v.wdata);
    s_ack_i   = 1'b1;
    s_rdata_i = 32'hBAD0_0000;
    tick();
    check("idle_s_req", s_req_o, 0);
    check("idle_no_ack", ack_o, 0);
    check("idle_rdata", rdata_o, last_rd);
    tick();
    check("idle_stays", s_req_o, 0);
    check("idle_no_ack2", ack_o, 0);
    s_ack_i = 1'b0;
    grant_i = '0;
    req_i   = '0;
  endtask

  initial begin
    vecs[0] = '{3'b010, 3'b010, 1'b1, 1, 16'h1234, 32'hA5A5_0001, 32'h0000_1111, 0, 1'b1};
    vecs[1] = '{3'b001, 3'b001, 1'b0, 0, 16'h0040, 32'h0000_0000, 32'hDEAD_BEEF, 1, 1'b1};
    vecs[2] = '{3'b011, 3'b011, 1'b1, 0, 16'h0011, 32'h0000_0011, 32'h0,         0, 1'b0};
    vecs[3] = '{3'b000, 3'b111, 1'b1, 0, 16'h0022, 32'h0000_0022, 32'h0,         0, 1'b0};
    vecs[4] = '{3'b100, 3'b011, 1'b1, 2, 16'h0033, 32'h0000_0033, 32'h0,         0, 1'b0};
    vecs[5] = '{3'b100, 3'b110, 1'b1, 2, 16'hBEEF, 32'h1357_9BDF, 32'h0BAD_F00D, 3, 1'b1};
    vecs[6] = '{3'b010, 3'b011, 1'b0, 1, 16'hFFFF, 32'hFFFF_FFFF, 32'h8000_0001, 2, 1'b1};
    vecs[7] = '{3'b110, 3'b110, 1'b0, 1, 16'h0044, 32'h0000_0044, 32'h0,         0, 1'b0};

    rst_n     = 1'b0;
    grant_i   = '0;
    req_i     = '0;
    we_i      = '0;
    addr_i    = '0;
    wdata_i   = '0;
    s_ack_i   = 1'b0;
    s_rdata_i = '0;
    #1;
    check("rst_s_req", s_req_o, 0);
    check("rst_ack", ack_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_s_addr", s_addr_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].start) begin
        start_txn(vecs[i].master, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 1'b1);
        finish_txn(vecs[i].delay, vecs[i].rdata, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      end else begin
        idle_vec(vecs[i]);
      end
    end

    // Unacknowledged transaction: aborts after 4 BUSY cycles only in the timeout build.
`ifdef BUS_GRANT_MUX_TIMEOUT_EN
    start_txn(0, 1'b0, 16'h0BAD, 32'h0, 32'h0, 1'b0);
    grant_i = '0;
    req_i   = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_wait_s_req", s_req_o, 1);
      check("to_wait_err", err_o, 0);
    end
    tick();
    check("to_err", err_o, 3'b001);
    check("to_no_ack", ack_o, 0);
    check("to_s_req_drop", s_req_o, 0);
    check("to_rdata_hold", rdata_o, last_rd);
    tick();
    check("to_err_one_cycle", err_o, 0);
    check("to_done_s_req", s_req_o, 0);
`else
    start_txn(0, 1'b0, 16'h0BAD, 32'h0, 32'h7777_0000, 1'b1);
    grant_i = '0;
    req_i   = '0;
    repeat (20) @(posedge clk);
    #1;
    check("nto_s_req", s_req_o, 1);
    check("nto_err", err_o, 0);
    check("nto_ack", ack_o, 0);
    finish_txn(0, 32'h7777_0000, 1'b0, 16'h0BAD, 32'h0);
`endif

    start_txn(2, 1'b1, 16'h5A5A, 32'hC0DE_CAFE, 32'h0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_s_req", s_req_o, 0);
    check("mrst_s_we", s_we_o, 0);
    check("mrst_s_addr", s_addr_o, 0);
    check("mrst_s_wdata", s_wdata_o, 0);
    check("mrst_ack", ack_o, 0);
    check("mrst_err", err_o, 0);
    check("mrst_rdata", rdata_o, 0);
    last_rd   = '0;
    s_ack_i   = 1'b1;
    s_rdata_i = 32'h1111_2222;
    grant_i   = '0;
    req_i     = '0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ack", ack_o, 0);
    check("post_rst_s_req", s_req_o, 0);
    check("post_rst_rdata", rdata_o, 0);
    s_ack_i = 1'b0;
    tick();
    start_txn(1, 1'b0, 16'h00A0, 32'h0, 32'h2468_ACE0, 1'b1);
    finish_txn(1, 32'h2468_ACE0, 1'b0, 16'h00A0, 32'h0);

    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
